fp_compare_unit: RTL and testbench

- Pipelined, parametrised floating-point compare/min/max unit for the FP execute stage.
- Takes two operands of any IEEE-754 binary format (EXPONENT_WIDTH/FRACTION_WIDTH) plus a command and a tag.
- Returns an integer result (FEQ/FLT/FLE), an FP result (FMIN/FMAX) and fflags after a fixed 2-stage pipeline.
- Uses valid/ready handshakes on both sides, with backpressure and flush.

---
 rtl/fp_compare_unit.sv | 150 +++++++++++++++
 tb/tb_fp_compare_unit.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fp_compare_unit.sv
// fp_compare_unit: 2-stage IEEE-754 compare/min/max pipeline with valid/ready handshakes and flush.
// Define FP_COMPARE_CLASSIFY_EN to add command 5 (Class of fpSrc1); otherwise command 5 is reserved.
module fp_compare_unit #(
   parameter int EXPONENT_WIDTH = 8,
   parameter int FRACTION_WIDTH = 23,
   localparam int WIDTH = 1 + EXPONENT_WIDTH + FRACTION_WIDTH,
   parameter int TAG_WIDTH = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 flush,
   input  logic                 inValid,
   output logic                 inReady,
   input  logic [2:0]           command,
   input  logic [WIDTH-1:0]     fpSrc1,
   input  logic [WIDTH-1:0]     fpSrc2,
   input  logic [TAG_WIDTH-1:0] inTag,
   output logic                 outValid,
   input  logic                 outReady,
   output logic [31:0]          intResult,
   output logic [WIDTH-1:0]     fpResult,
   output logic [4:0]           flags,
   output logic [TAG_WIDTH-1:0] outTag
);
   localparam logic [WIDTH-1:0] QNAN = {1'b0, {EXPONENT_WIDTH{1'b1}}, 1'b1, {(FRACTION_WIDTH-1){1'b0}}};
   typedef struct packed {
      logic nan;
      logic snan;
      logic zero;
   } cls_t;
   typedef struct packed {
      logic [2:0]           cmd;
      logic [TAG_WIDTH-1:0] tag;
      logic [WIDTH-1:0]     a;
      logic [WIDTH-1:0]     b;
      cls_t                 ca;
      cls_t                 cb;
      logic                 eq_bits;
      logic                 mag_lt;
`ifdef FP_COMPARE_CLASSIFY_EN
      logic [9:0]           class_mask;
`endif
   } s1_t;
   function automatic cls_t classify(input logic [WIDTH-1:0] x);
      cls_t c;
      c.nan = (&x[WIDTH-2 -: EXPONENT_WIDTH]) && (|x[FRACTION_WIDTH-1:0]);
      c.snan = c.nan && !x[FRACTION_WIDTH-1];
      c.zero = ~|x[WIDTH-2:0];
      return c;
   endfunction
`ifdef FP_COMPARE_CLASSIFY_EN
   function automatic logic [9:0] class_of(input logic [WIDTH-1:0] x);
      logic s, e1, e0, f0;
      logic [3:0] idx;
      s = x[WIDTH-1];
      e1 = &x[WIDTH-2 -: EXPONENT_WIDTH];
      e0 = ~|x[WIDTH-2 -: EXPONENT_WIDTH];
      f0 = ~|x[FRACTION_WIDTH-1:0];
      idx = (e1 && !f0) ? (x[FRACTION_WIDTH-1] ? 4'd9 : 4'd8) :
            e1 ? (s ? 4'd0 : 4'd7) :
            (e0 && f0) ? (s ? 4'd3 : 4'd4) :
            e0 ? (s ? 4'd2 : 4'd5) : (s ? 4'd1 : 4'd6);
      return 10'd1 << idx;
   endfunction
`endif
   logic                 s1_valid_q, s1_valid_d, s2_valid_q, s2_valid_d;
   logic                 s1_ready, s2_ready;
   s1_t                  s1_q, s1_d;
   logic [31:0]          int_result_q, int_result_d;
   logic [WIDTH-1:0]     fp_result_q, fp_result_d;
   logic [4:0]           flags_q, flags_d;
   logic [TAG_WIDTH-1:0] out_tag_q, out_tag_d;
   logic                 sa, sb, any_nan, any_snan, both_zero, lt_ord, feq, flt, nv;
   assign s2_ready = !s2_valid_q || outReady;
   assign s1_ready = !s1_valid_q || s2_ready;
   assign inReady  = s1_ready;
   assign outValid  = s2_valid_q;
   assign intResult = int_result_q;
   assign fpResult  = fp_result_q;
   assign flags     = flags_q;
   assign outTag    = out_tag_q;
   always_comb begin
      s1_valid_d = flush ? 1'b0 : (s1_ready ? inValid : s1_valid_q);
      s1_d = s1_q;
      if (inValid && s1_ready) begin
         s1_d.cmd = command;
         s1_d.tag = inTag;
         s1_d.a = fpSrc1;
         s1_d.b = fpSrc2;
         s1_d.ca = classify(fpSrc1);
         s1_d.cb = classify(fpSrc2);
         s1_d.eq_bits = fpSrc1 == fpSrc2;
         s1_d.mag_lt = fpSrc1[WIDTH-2:0] < fpSrc2[WIDTH-2:0];
`ifdef FP_COMPARE_CLASSIFY_EN
         s1_d.class_mask = class_of(fpSrc1);
`endif
      end
   end
   // lt_ord is a total order where -0 < +0; plain Lt masks out the both-zero case.
   always_comb begin
      sa = s1_q.a[WIDTH-1];
      sb = s1_q.b[WIDTH-1];
      any_nan = s1_q.ca.nan || s1_q.cb.nan;
      any_snan = s1_q.ca.snan || s1_q.cb.snan;
      both_zero = s1_q.ca.zero && s1_q.cb.zero;
      lt_ord = (sa != sb) ? sa : (sa ? !(s1_q.mag_lt || s1_q.eq_bits) : s1_q.mag_lt);
      feq = !any_nan && (s1_q.eq_bits || both_zero);
      flt = !any_nan && !both_zero && lt_ord;
      nv = (s1_q.cmd == 3'd1 || s1_q.cmd == 3'd2) ? any_nan :
           (s1_q.cmd == 3'd0 || s1_q.cmd == 3'd3 || s1_q.cmd == 3'd4) ? any_snan : 1'b0;
      s2_valid_d = flush ? 1'b0 : (s2_ready ? s1_valid_q : s2_valid_q);
      int_result_d = int_result_q;
      fp_result_d = fp_result_q;
      flags_d = flags_q;
      out_tag_d = out_tag_q;
      if (s1_valid_q && s2_ready) begin
         int_result_d = {31'd0, s1_q.cmd == 3'd0 ? feq : s1_q.cmd == 3'd1 ? flt : s1_q.cmd == 3'd2 ? (feq || flt) : 1'b0};
`ifdef FP_COMPARE_CLASSIFY_EN
         if (s1_q.cmd == 3'd5) int_result_d = {22'd0, s1_q.class_mask};
`endif
         fp_result_d = (s1_q.cmd != 3'd3 && s1_q.cmd != 3'd4) ? '0 :
                       (s1_q.ca.nan && s1_q.cb.nan) ? QNAN :
                       s1_q.ca.nan ? s1_q.b :
                       s1_q.cb.nan ? s1_q.a :
                       (s1_q.cmd == 3'd3) ? ((lt_ord || s1_q.eq_bits) ? s1_q.a : s1_q.b) :
                       (lt_ord ? s1_q.b : s1_q.a);
         flags_d = {nv, 4'd0};
         out_tag_d = s1_q.tag;
      end
   end
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         s1_valid_q <= 1'b0;
         s2_valid_q <= 1'b0;
         s1_q <= '0;
         int_result_q <= '0;
         fp_result_q <= '0;
         flags_q <= '0;
         out_tag_q <= '0;
      end else begin
         s1_valid_q <= s1_valid_d;
         s2_valid_q <= s2_valid_d;
         s1_q <= s1_d;
         int_result_q <= int_result_d;
         fp_result_q <= fp_result_d;
         flags_q <= flags_d;
         out_tag_q <= out_tag_d;
      end
   end
endmodule

// File: tb/tb_fp_compare_unit.sv
// tb_fp_compare_unit: vector table, directed handshake/flush/reset sequences and a randomized
// scoreboard run against an ordering-key reference model of fp_compare_unit.
module tb_fp_compare_unit;
   localparam logic [31:0] QNAN = 32'h7FC00000;
   logic        clk = 0, rst = 0, flush = 0, inValid = 0, outReady = 1;
   logic        inReady, outValid;
   logic [2:0]  command = 0;
   logic [31:0] fpSrc1 = 0, fpSrc2 = 0;
   logic [4:0]  inTag = 0, outTag;
   logic [31:0] intResult, fpResult;
   logic [4:0]  flags;

   fp_compare_unit dut (
      .clk(clk), .rst(rst), .flush(flush), .inValid(inValid), .inReady(inReady),
      .command(command), .fpSrc1(fpSrc1), .fpSrc2(fpSrc2), .inTag(inTag),
      .outValid(outValid), .outReady(outReady), .intResult(intResult),
      .fpResult(fpResult), .flags(flags), .outTag(outTag)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0]  cmd;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] ir;
      logic [31:0] fr;
      logic [4:0]  fl;
   } vec_t;
   typedef struct {
      logic [31:0] ir;
      logic [31:0] fr;
      logic [4:0]  fl;
      logic [4:0]  tag;
   } exp_t;

   int n_chk = 0, n_pass = 0;
   int n_acc = 0, n_rcv = 0;
   bit sb_on = 0;
   exp_t sbq[$];
   exp_t mon_e;
   vec_t vecs[17];
   logic [31:0] specials[12];

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] want);
      n_chk++;
      if (got === want) n_pass++;
      else $display("FAIL %s: got %0h required %0h", name, got, want);
   endtask

   function automatic bit is_nan(input logic [31:0] x);
      return x[30:23] == 8'hFF && x[22:0] != 0;
   endfunction
   function automatic bit is_snan(input logic [31:0] x);
      return is_nan(x) && !x[22];
   endfunction
   // Signed integer key: IEEE magnitudes order like integers, sign applied arithmetically.
   function automatic longint key(input logic [31:0] x);
      return x[31] ? -longint'(x[30:0]) : longint'(x[30:0]);
   endfunction

   function automatic exp_t model(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] tag);
      exp_t r;
      bit na, nb, sn, less, greater;
      longint ka, kb;
      na = is_nan(a);
      nb = is_nan(b);
      sn = is_snan(a) || is_snan(b);
      ka = key(a);
      kb = key(b);
      less = ka < kb || (ka == kb && a[31] && !b[31]);
      greater = ka > kb || (ka == kb && !a[31] && b[31]);
      r.ir = 0; r.fr = 0; r.fl = 0; r.tag = tag;
      if (c == 0) begin r.ir = {31'd0, !(na || nb) && ka == kb}; r.fl[4] = sn; end
      if (c == 1) begin r.ir = {31'd0, !(na || nb) && ka < kb}; r.fl[4] = na || nb; end
      if (c == 2) begin r.ir = {31'd0, !(na || nb) && ka <= kb}; r.fl[4] = na || nb; end
      if (c == 3 || c == 4) begin
         r.fl[4] = sn;
         r.fr = (na && nb) ? QNAN : na ? b : nb ? a : (c == 3 ? (greater ? b : a) : (less ? b : a));
      end
`ifdef FP_COMPARE_CLASSIFY_EN
      if (c == 5) begin
         int k;
         if (na) k = is_snan(a) ? 8 : 9;
         else if (a[30:23] == 8'hFF) k = a[31] ? 0 : 7;
         else if (a[30:0] == 0) k = a[31] ? 3 : 4;
         else if (a[30:23] == 0) k = a[31] ? 2 : 5;
         else k = a[31] ? 1 : 6;
         r.ir = 32'd1 << k;
      end
`endif
      return r;
   endfunction

   always @(negedge clk) begin
      if (sb_on && rst) begin
         if (outValid && outReady) begin
            if (sbq.size() == 0) begin
               n_chk++;
               $display("FAIL sb_extra: got result tag %0h, required no result", outTag);
            end else begin
               mon_e = sbq.pop_front();
               chk("sb_tag", outTag, mon_e.tag);
               chk("sb_int", intResult, mon_e.ir);
               chk("sb_fp", fpResult, mon_e.fr);
               chk("sb_flags", flags, mon_e.fl);
               n_rcv++;
            end
         end
         if (inValid && inReady && !flush) begin
            sbq.push_back(model(command, fpSrc1, fpSrc2, inTag));
            n_acc++;
         end
      end
   end

   task automatic run_vec(input vec_t v, input int idx);
      @(posedge clk); #1;
      command = v.cmd; fpSrc1 = v.a; fpSrc2 = v.b; inTag = idx[4:0]; inValid = 1;
      @(posedge clk); #1;
      inValid = 0;
      chk("vec_not_early", outValid, 0);
      @(posedge clk); #1;
      chk("vec_latency", outValid, 1);
      chk("vec_int", intResult, v.ir);
      chk("vec_fp", fpResult, v.fr);
      chk("vec_flags", flags, v.fl);
      chk("vec_tag", outTag, idx[4:0]);
   endtask

   task automatic send(input logic [2:0] c, input logic [31:0] a, input logic [31:0] b, input logic [4:0] t);
      bit got;
      got = 0;
      command = c; fpSrc1 = a; fpSrc2 = b; inTag = t; inValid = 1;
      for (int w = 0; w < 50 && !got; w++) begin
         @(negedge clk);
         got = inReady;
      end
      @(posedge clk); #1;
      inValid = 0;
      if (!got) begin
         n_chk++;
         $display("FAIL send_timeout: got inReady 0 for 50 cycles, required 1");
      end
   endtask

   function automatic logic [31:0] rnd_op();
      return ($urandom % 2) ? specials[$urandom_range(11)] : $urandom;
   endfunction

   initial begin
      int seen;
      exp_t e1;
      specials = '{32'h00000000, 32'h80000000, 32'h3F800000, 32'hBF800000, 32'h7F800000, 32'hFF800000,
                   32'h7FC00000, 32'hFFC00000, 32'h7F800001, 32'hFFA00000, 32'h00000001, 32'h80400000};
      vecs[0]  = '{3'd1, 32'h3F800000, 32'h40000000, 32'd1, 32'h0, 5'h00};
      vecs[1]  = '{3'd0, 32'h00000000, 32'h80000000, 32'd1, 32'h0, 5'h00};
      vecs[2]  = '{3'd3, 32'h00000000, 32'h80000000, 32'd0, 32'h80000000, 5'h00};
      vecs[3]  = '{3'd4, 32'h00000000, 32'h80000000, 32'd0, 32'h00000000, 5'h00};
      vecs[4]  = '{3'd4, 32'h7F800001, 32'h7FC00000, 32'd0, 32'h7FC00000, 5'h10};
      vecs[5]  = '{3'd3, 32'h7FC00000, 32'hBF800000, 32'd0, 32'hBF800000, 5'h00};
      vecs[6]  = '{3'd2, 32'h7FC00000, 32'h3F800000, 32'd0, 32'h0, 5'h10};
      vecs[7]  = '{3'd0, 32'h7FC00000, 32'h3F800000, 32'd0, 32'h0, 5'h00};
      vecs[8]  = '{3'd1, 32'hBF800000, 32'hC0000000, 32'd0, 32'h0, 5'h00};
      vecs[9]  = '{3'd2, 32'h40000000, 32'h40000000, 32'd1, 32'h0, 5'h00};
      vecs[10] = '{3'd1, 32'h80000000, 32'h00000000, 32'd0, 32'h0, 5'h00};
      vecs[11] = '{3'd3, 32'h7FC00000, 32'h7F800001, 32'd0, 32'h7FC00000, 5'h10};
      vecs[12] = '{3'd4, 32'hC0000000, 32'hBF800000, 32'd0, 32'hBF800000, 5'h00};
      vecs[13] = '{3'd7, 32'h3F800000, 32'h40000000, 32'd0, 32'h0, 5'h00};
      vecs[14] = '{3'd0, 32'h7F800001, 32'h7F800001, 32'd0, 32'h0, 5'h10};
      vecs[15] = '{3'd1, 32'hFF800000, 32'h7F800000, 32'd1, 32'h0, 5'h00};
`ifdef FP_COMPARE_CLASSIFY_EN
      vecs[16] = '{3'd5, 32'h80000000, 32'h3F800000, 32'd8, 32'h0, 5'h00};
`else
      vecs[16] = '{3'd5, 32'h80000000, 32'h3F800000, 32'd0, 32'h0, 5'h00};
`endif
      // reset values
      #12;
      chk("rst_outValid", outValid, 0);
      chk("rst_int", intResult, 0);
      chk("rst_fp", fpResult, 0);
      chk("rst_flags", flags, 0);
      chk("rst_tag", outTag, 0);
      @(negedge clk); rst = 1;
      @(posedge clk); #1;
      chk("rst_inReady", inReady, 1);

      for (int i = 0; i < 17; i++) run_vec(vecs[i], i + 1);

      // backpressure: 4 ops with outReady low
      @(posedge clk); #1;
      sb_on = 1; n_acc = 0; n_rcv = 0; outReady = 0;
      e1 = model(3'd1, 32'h3F800000, 32'h40000000, 5'd1);
      fork
         begin
            send(3'd1, 32'h3F800000, 32'h40000000, 5'd1);
            send(3'd4, 32'hC0000000, 32'h3F800000, 5'd2);
            send(3'd0, 32'h00000000, 32'h80000000, 5'd3);
            send(3'd3, 32'hFF800000, 32'h7FC00000, 5'd4);
         end
         begin
            repeat (4) @(posedge clk);
            #1;
            chk("bp_accepted_2", n_acc, 2);
            chk("bp_inReady_low", inReady, 0);
            chk("bp_outValid", outValid, 1);
            chk("bp_hold_tag", outTag, e1.tag);
            chk("bp_hold_int", intResult, e1.ir);
            repeat (3) @(posedge clk);
            #1;
            chk("bp_still_2", n_acc, 2);
            chk("bp_hold_tag2", outTag, e1.tag);
            chk("bp_hold_int2", intResult, e1.ir);
            chk("bp_hold_fp2", fpResult, e1.fr);
            outReady = 1;
         end
      join
      for (int w = 0; w < 40 && n_rcv < 4; w++) @(posedge clk);
      #1;
      chk("bp_accepted", n_acc, 4);
      chk("bp_received", n_rcv, 4);
      sb_on = 0;

      // flush with both stages full and a simultaneous request
      outReady = 0;
      send(3'd1, 32'h3F800000, 32'h40000000, 5'd5);
      send(3'd1, 32'h3F800000, 32'h40000000, 5'd6);
      chk("fl_full_outValid", outValid, 1);
      chk("fl_full_inReady", inReady, 0);
      flush = 1; inValid = 1; inTag = 5'd7;
      @(posedge clk); #1;
      flush = 0; inValid = 0;
      chk("fl_outValid", outValid, 0);
      chk("fl_inReady", inReady, 1);
      outReady = 1;
      seen = 0;
      repeat (4) begin @(posedge clk); #1; seen += int'(outValid); end
      chk("fl_no_emit", seen, 0);
      // flush wins over an accept into an empty pipeline
      flush = 1; inValid = 1; inTag = 5'd8;
      @(posedge clk); #1;
      flush = 0; inValid = 0;
      seen = 0;
      repeat (4) begin @(posedge clk); #1; seen += int'(outValid); end
      chk("fl_drop_accept", seen, 0);

      // asynchronous reset mid-stream
      outReady = 0;
      send(3'd1, 32'h3F800000, 32'h40000000, 5'd9);
      @(posedge clk); #1;
      chk("ar_outValid_before", outValid, 1);
      chk("ar_int_before", intResult, 1);
      #2 rst = 0;
      #1;
      chk("ar_outValid", outValid, 0);
      chk("ar_int", intResult, 0);
      chk("ar_tag", outTag, 0);
      @(negedge clk); rst = 1; outReady = 1;
      @(posedge clk); #1;
      chk("ar_inReady", inReady, 1);

      // randomized stream against the model
      sbq.delete(); n_acc = 0; n_rcv = 0; sb_on = 1;
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         inValid = ($urandom % 4) != 0;
         outReady = ($urandom % 4) != 0;
         command = 3'($urandom % 8);
         inTag = 5'($urandom);
         fpSrc1 = rnd_op();
         case ($urandom % 4)
            0: fpSrc2 = fpSrc1;
            1: fpSrc2 = fpSrc1 ^ 32'h80000000;
            default: fpSrc2 = rnd_op();
         endcase
      end
      @(posedge clk); #1;
      inValid = 0; outReady = 1;
      for (int w = 0; w < 20 && sbq.size() != 0; w++) @(posedge clk);
      #1;
      chk("rnd_drained", n_rcv, n_acc);
      sb_on = 0;

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
